instr_fetch_unit: RTL and testbench

Instruction fetch front end for the single-cycle CPU datapath. It owns the fetch PC and issues requests to an instruction memory with variable latency. Returned words are buffered with their PCs in a small in-order queue and handed downstream through a valid/ready handshake. A branch/jump redirect from the datapath flushes the queue and discards any stale memory responses.

---
 rtl/fetch_pkg.sv | 12 +
 rtl/fetch_fifo.sv | 96 +++++++++
 rtl/instr_fetch_unit.sv | 131 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } fetch_state_e;

    localparam int INSTR_W = 32;
    localparam int PC_STEP = 4;

endpackage

// File: rtl/fetch_fifo.sv
// In-order queue of {pc, instr} pairs between memory responses and the consumer.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int PC_W  = 32,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               push_i,
    input  logic [PC_W-1:0]    push_pc_i,
    input  logic [INSTR_W-1:0] push_instr_i,
    input  logic               pop_i,
    input  logic               flush_i,
    output logic               head_valid_o,
    output logic [PC_W-1:0]    head_pc_o,
    output logic [INSTR_W-1:0] head_instr_o,
    output logic [CNT_W-1:0]   count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PC_W-1:0]    pc_mem_q    [DEPTH];
    logic [PC_W-1:0]    pc_mem_d    [DEPTH];
    logic [INSTR_W-1:0] instr_mem_q [DEPTH];
    logic [INSTR_W-1:0] instr_mem_d [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end else begin
            return p + 1'b1;
        end
    endfunction

    // Next-state for storage, pointers and occupancy; flush overrides push/pop.
    always_comb begin
        pc_mem_d    = pc_mem_q;
        instr_mem_d = instr_mem_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) begin
                pc_mem_d[wr_ptr_q]    = push_pc_i;
                instr_mem_d[wr_ptr_q] = push_instr_i;
                wr_ptr_d              = ptr_inc(wr_ptr_q);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Queue state registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]    <= '0;
                instr_mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pc_mem_q    <= pc_mem_d;
            instr_mem_q <= instr_mem_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
        end
    end

    assign head_valid_o = (count_q != '0);
    assign head_pc_o    = head_valid_o ? pc_mem_q[rd_ptr_q] : '0;
    assign head_instr_o = head_valid_o ? instr_mem_q[rd_ptr_q] : '0;
    assign count_o      = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front end: owns the fetch PC, throttles requests to the queue capacity,
// and drops responses made stale by a redirect.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int               ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h0000_0000),
    parameter int               DEPTH    = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    output logic               mem_req_o,
    output logic [ADDR_W-1:0]  mem_addr_o,
    input  logic               mem_gnt_i,
    input  logic               mem_rvalid_i,
    input  logic [INSTR_W-1:0] mem_rdata_i,
    input  logic               redirect_i,
    input  logic [ADDR_W-1:0]  redirect_pc_i,
    output logic               instr_valid_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [ADDR_W-1:0]  instr_pc_o,
    input  logic               instr_ready_i
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SUM_W = CNT_W + 1;

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0]  outstanding_q, outstanding_d;
    logic [CNT_W-1:0]  discard_q, discard_d;

    logic [CNT_W-1:0]  count_s;
    logic [SUM_W-1:0]  occupancy_s;
    logic [ADDR_W-1:0] redirect_pc_s;
    logic [CNT_W-1:0]  discard_base_s;
    logic              pop_s;
    logic              resp_s;
    logic              push_s;
    logic              req_s;
    logic              grant_s;

    assign pop_s         = instr_valid_o & instr_ready_i;
    assign resp_s        = mem_rvalid_i & (outstanding_q != '0);
    assign push_s        = resp_s & (discard_q == '0) & ~redirect_i;
    assign redirect_pc_s = redirect_pc_i & ~ADDR_W'(32'h0000_0003);

    // Queued plus in-flight entries after this cycle's pop must leave room for one more.
    assign occupancy_s = {1'b0, count_s} + {1'b0, outstanding_q} - {{CNT_W{1'b0}}, pop_s};
    assign req_s       = rst_i & (state_q == FETCH) & ~redirect_i & (occupancy_s < SUM_W'(DEPTH));
    assign grant_s     = req_s & mem_gnt_i;

    assign mem_req_o  = req_s;
    assign mem_addr_o = fetch_pc_q;

    // Next-state for PCs, counters and the control FSM.
    always_comb begin
        state_d        = state_q;
        fetch_pc_d     = fetch_pc_q;
        resp_pc_d      = resp_pc_q;
        discard_d      = discard_q;
        discard_base_s = (state_q == DRAIN) ? discard_q : outstanding_q;

        case ({grant_s, resp_s})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01:   outstanding_d = outstanding_q - 1'b1;
            default: outstanding_d = outstanding_q;
        endcase

        if (redirect_i) begin
            fetch_pc_d = redirect_pc_s;
            resp_pc_d  = redirect_pc_s;
            discard_d  = discard_base_s - {{(CNT_W-1){1'b0}}, resp_s};
            state_d    = (discard_d != '0) ? DRAIN : FETCH;
        end else begin
            if (grant_s) begin
                fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
            end else begin
                fetch_pc_d = fetch_pc_q;
            end
            if (resp_s && (discard_q != '0)) begin
                discard_d = discard_q - 1'b1;
            end else if (resp_s) begin
                resp_pc_d = resp_pc_q + ADDR_W'(PC_STEP);
            end else begin
                discard_d = discard_q;
            end
            case (state_q)
                FETCH:   state_d = FETCH;
                DRAIN:   state_d = (discard_d == '0) ? FETCH : DRAIN;
                default: state_d = FETCH;
            endcase
        end
    end

    // Control and PC registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q       <= FETCH;
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .PC_W  (ADDR_W)
    ) u_fifo (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .push_i       (push_s),
        .push_pc_i    (resp_pc_q),
        .push_instr_i (mem_rdata_i),
        .pop_i        (pop_s),
        .flush_i      (redirect_i),
        .head_valid_o (instr_valid_o),
        .head_pc_o    (instr_pc_o),
        .head_instr_o (instr_o),
        .count_o      (count_s)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit against a request-tagging queue model,
// plus directed sequences with hand-computed expectations.
module tb_instr_fetch_unit;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .ADDR_W   (32),
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .mem_req_o     (mem_req_o),
        .mem_addr_o    (mem_addr_o),
        .mem_gnt_i     (mem_gnt_i),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_rdata_i   (mem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .instr_ready_i (instr_ready_i)
    );

    // Every accepted request is remembered with its PC; a redirect marks all of them stale.
    typedef struct {
        logic [31:0] pc;
        bit          stale;
        int          due;
    } req_t;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    req_t        inflight[$];
    ent_t        q[$];
    logic [31:0] m_fetch_pc;
    int          cyc = 0;
    int          n_pass = 0;
    int          n_total = 0;

    bit          rst_drv;
    int          gnt_pct, ready_pct, redir_pct, spur_pct, lat_min, lat_max;
    bit          force_redir;
    logic [31:0] force_pc;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        inflight.delete();
        q.delete();
        m_fetch_pc = RESET_PC;
    endtask

    task automatic step();
        bit          redir, rv, pop_e, req_e, drain;
        logic [31:0] rpc, rdata;
        int          occ, lat;
        req_t        e;
        ent_t        n;
        @(posedge clk);
        #1;
        cyc++;
        if (!rst_drv) model_reset();
        redir = rst_drv && (force_redir || (($urandom % 100) < redir_pct));
        if (force_redir) rpc = force_pc;
        else if (($urandom % 8) == 0) rpc = $urandom;
        else rpc = $urandom & 32'h0000_0FFF;
        if (inflight.size() > 0) rv = (inflight[0].due <= cyc);
        else rv = (($urandom % 100) < spur_pct);
        rdata         = $urandom;
        rst_i         = rst_drv;
        redirect_i    = redir;
        redirect_pc_i = rpc;
        mem_rvalid_i  = rv;
        mem_rdata_i   = rdata;
        mem_gnt_i     = (($urandom % 100) < gnt_pct);
        instr_ready_i = (($urandom % 100) < ready_pct);
        #3;
        if (!rst_drv) begin
            check("rst_req", {31'b0, mem_req_o}, 32'd0);
            check("rst_addr", mem_addr_o, RESET_PC);
            check("rst_valid", {31'b0, instr_valid_o}, 32'd0);
            check("rst_instr", instr_o, 32'd0);
            check("rst_pc", instr_pc_o, 32'd0);
            return;
        end
        drain = 1'b0;
        foreach (inflight[i]) if (inflight[i].stale) drain = 1'b1;
        pop_e = (q.size() > 0) && instr_ready_i;
        occ   = q.size() + inflight.size() - int'(pop_e);
        req_e = !drain && !redir && (occ < DEPTH);
        check("mem_req", {31'b0, mem_req_o}, {31'b0, req_e});
        check("mem_addr", mem_addr_o, m_fetch_pc);
        check("instr_valid", {31'b0, instr_valid_o}, {31'b0, (q.size() > 0)});
        check("instr", instr_o, (q.size() > 0) ? q[0].instr : 32'd0);
        check("instr_pc", instr_pc_o, (q.size() > 0) ? q[0].pc : 32'd0);
        if (pop_e) void'(q.pop_front());
        if (rv && inflight.size() > 0) begin
            e = inflight.pop_front();
            if (!e.stale && !redir) begin
                n.pc    = e.pc;
                n.instr = rdata;
                q.push_back(n);
            end
        end
        if (redir) begin
            q.delete();
            foreach (inflight[i]) inflight[i].stale = 1'b1;
            m_fetch_pc = rpc & 32'hFFFF_FFFC;
        end else if (req_e && mem_gnt_i) begin
            lat   = lat_min + int'($urandom % (lat_max - lat_min + 1));
            e.pc    = m_fetch_pc;
            e.stale = 1'b0;
            e.due   = cyc + lat;
            inflight.push_back(e);
            m_fetch_pc = m_fetch_pc + 32'd4;
        end
    endtask

    task automatic set_knobs(input int g, input int r, input int rd, input int lmin, input int lmax);
        gnt_pct = g; ready_pct = r; redir_pct = rd; lat_min = lmin; lat_max = lmax;
        spur_pct = 0; force_redir = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst_drv = 1'b0;
        repeat (n) step();
        rst_drv = 1'b1;
    endtask

    initial begin
        rst_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'd0;
        redirect_i = 1'b0; redirect_pc_i = 32'd0; instr_ready_i = 1'b0;
        force_pc = 32'd0;
        model_reset();

        // Steady fetch, then 5 cycles of backpressure.
        set_knobs(100, 100, 0, 1, 1);
        do_reset(3);
        step(); check("A0_req", {31'b0, mem_req_o}, 32'd1); check("A0_addr", mem_addr_o, 32'h0);
        step();
        step(); check("A2_valid", {31'b0, instr_valid_o}, 32'd1); check("A2_pc", instr_pc_o, 32'h0);
        step(); check("A3_pc", instr_pc_o, 32'h4);
        ready_pct = 0;
        repeat (5) begin
            step(); check("bp_pc", instr_pc_o, 32'h8); check("bp_req", {31'b0, mem_req_o}, 32'd0);
        end
        ready_pct = 100;
        step(); check("A9_pc", instr_pc_o, 32'h8);
        step(); check("A10_pc", instr_pc_o, 32'hC);
        step(); check("A11_pc", instr_pc_o, 32'h10);

        // Redirect with two requests in flight, latency 3.
        set_knobs(100, 100, 0, 3, 3);
        do_reset(2);
        step(); step();
        force_redir = 1'b1; force_pc = 32'h0000_0103;
        step();
        force_redir = 1'b0;
        step(); check("B3_req", {31'b0, mem_req_o}, 32'd0); check("B3_addr", mem_addr_o, 32'h100);
        step(); check("B4_req", {31'b0, mem_req_o}, 32'd0);
        step(); check("B5_req", {31'b0, mem_req_o}, 32'd1); check("B5_addr", mem_addr_o, 32'h100);
        step(); step(); step();
        step(); check("B9_valid", {31'b0, instr_valid_o}, 32'd1); check("B9_pc", instr_pc_o, 32'h100);

        // Redirect together with a response and a pop.
        set_knobs(100, 100, 0, 1, 1);
        do_reset(2);
        step(); step();
        force_redir = 1'b1; force_pc = 32'h0000_0040;
        step(); check("C2_pc", instr_pc_o, 32'h0);
        force_redir = 1'b0;
        step(); check("C3_valid", {31'b0, instr_valid_o}, 32'd0);
        check("C3_req", {31'b0, mem_req_o}, 32'd1); check("C3_addr", mem_addr_o, 32'h40);
        repeat (4) step();

        // Second redirect during DRAIN, then reset mid-DRAIN and a stray response.
        set_knobs(100, 100, 0, 4, 4);
        do_reset(2);
        step(); step();
        force_redir = 1'b1; force_pc = 32'h0000_0300;
        step();
        force_pc = 32'h0000_0200;
        step();
        force_redir = 1'b0;
        step(); check("D4_addr", mem_addr_o, 32'h200); check("D4_req", {31'b0, mem_req_o}, 32'd0);
        do_reset(1);
        spur_pct = 100;
        step();
        spur_pct = 0;
        repeat (10) step();

        // Stalled grant across the address wrap.
        set_knobs(0, 100, 0, 1, 1);
        do_reset(2);
        force_redir = 1'b1; force_pc = 32'hFFFF_FFFF;
        step();
        force_redir = 1'b0;
        repeat (4) begin
            step(); check("E_req", {31'b0, mem_req_o}, 32'd1); check("E_addr", mem_addr_o, 32'hFFFF_FFFC);
        end
        gnt_pct = 100;
        step();
        step(); check("E_wrap", mem_addr_o, 32'h0);
        repeat (4) step();

        // Randomized traffic.
        for (int p = 0; p < 5; p++) begin
            case (p)
                0:       set_knobs(90, 90, 2, 1, 1);
                1:       set_knobs(60, 50, 5, 1, 4);
                2:       set_knobs(40, 30, 10, 2, 5);
                3:       set_knobs(80, 70, 3, 1, 3);
                default: set_knobs(70, 20, 15, 1, 6);
            endcase
            spur_pct = 5;
            repeat (1500) step();
            do_reset(1 + p);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
